// File: rtl/spi_slave_rxm_if.sv
// CPU register port and SPI pins of spi_slave_rxm.
// The slave modport is the block side; the master modport is the CPU/SPI-master side.
interface spi_slave_rxm_if;
  logic        spi_select;
  logic [2:0]  mem_addr;
  logic        read_n;
  logic        write_n;
  logic [15:0] data_from_cpu;
  logic [15:0] data_to_cpu;
  logic        irq;
  logic        dataavailable;
  logic        readyfordata;
  logic        SCLK;
  logic        SS_n;
  logic        MOSI;
  logic        MISO;
  logic        MISO_oe;

  modport slave (
    input  spi_select, mem_addr, read_n, write_n, data_from_cpu, SCLK, SS_n, MOSI,
    output data_to_cpu, irq, dataavailable, readyfordata, MISO, MISO_oe
  );

  modport master (
    output spi_select, mem_addr, read_n, write_n, data_from_cpu, SCLK, SS_n, MOSI,
    input  data_to_cpu, irq, dataavailable, readyfordata, MISO, MISO_oe
  );
endinterface

// File: rtl/spi_slave_rxm.sv
// SPI mode-0 slave with rxdata/txdata/status/control registers; register reads have 1-cycle latency.
// No backpressure: late tx data sends FILL_BYTE (TOE), unread rx data is overwritten (ROE); SPI_SLAVE_IRQ_EN adds control/irq.
module spi_slave_rxm #(
  parameter int              DATA_WIDTH  = 8,
  parameter int              SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] FILL_BYTE = 8'hFF
) (
  input  logic           clk,
  input  logic           reset,
  spi_slave_rxm_if.slave bus
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic {IDLE, FRAME} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q, fill_q;
  logic sclk_hist_q, ss_hist_q;
  logic sclk_s, ss_s, mosi_s, sclk_rise, sclk_fall, ss_rise, ss_fall;

  state_e                state_q, state_d;
  logic [CW-1:0]         bitcnt_q, bitcnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] rx_hold_q, rx_hold_d, tx_hold_q, tx_hold_d, rx_byte;
  logic primed_q, primed_d, rrdy_q, rrdy_d, fe_q, fe_d, roe_q, roe_d;
  logic toe_q, toe_d, eop_q, eop_d, armed_q, armed_d;
  logic [15:0] rdata_q, rdata_d, status;
  logic [7:0]  ctrl;
  logic wr, rd, rx_read, tx_wr, st_wr, load, trdy, tmt;
  logic unused_bits;

  // The fill flops keep the reset value of the SS_n chain from arming the block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      fill_q      <= '0;
      sclk_hist_q <= 1'b0;
      ss_hist_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.SCLK};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], bus.SS_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.MOSI};
      fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      sclk_hist_q <= sclk_s;
      ss_hist_q   <= ss_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign ss_rise   = ss_s & ~ss_hist_q;
  assign ss_fall   = ~ss_s & ss_hist_q;

  assign wr      = bus.spi_select & ~bus.write_n;
  assign rd      = bus.spi_select & ~bus.read_n;
  assign rx_read = rd & (bus.mem_addr == 3'd0);
  assign tx_wr   = wr & (bus.mem_addr == 3'd1);
  assign st_wr   = wr & (bus.mem_addr == 3'd2);
  assign trdy    = ~primed_q;
  assign tmt     = ~primed_q & (state_q == IDLE);
  assign rx_byte = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
  assign status  = {6'b0, eop_q, (roe_q | toe_q | fe_q), rrdy_q, trdy, tmt, toe_q, roe_q, fe_q, 2'b00};
  assign unused_bits = ^{bus.data_from_cpu, rx_shift_q[DATA_WIDTH-1]};

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    rx_shift_d = rx_shift_q;
    rx_hold_d  = rx_hold_q;
    tx_hold_d  = tx_hold_q;
    primed_d   = primed_q;
    rrdy_d     = rrdy_q;
    fe_d       = fe_q;
    roe_d      = roe_q;
    toe_d      = toe_q;
    eop_d      = eop_q;
    armed_d    = armed_q | (fill_q[SYNC_STAGES-1] & ss_s);
    rdata_d    = rdata_q;
    load       = 1'b0;

    // Clears are applied first so that same-cycle events win.
    if (st_wr) begin
      fe_d  = 1'b0;
      roe_d = 1'b0;
      toe_d = 1'b0;
      eop_d = 1'b0;
    end
    if (rx_read) rrdy_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (ss_fall && armed_q) begin
          state_d  = FRAME;
          bitcnt_d = '0;
          load     = 1'b1;
        end
      end
      FRAME: begin
        if (ss_rise) begin
          state_d = IDLE;
          eop_d   = 1'b1;
          if (bitcnt_q != '0) fe_d = 1'b1;
        end else if (sclk_rise) begin
          rx_shift_d = rx_byte;
          if (bitcnt_q == CW'(DATA_WIDTH-1)) begin
            bitcnt_d  = '0;
            rx_hold_d = rx_byte;
            rrdy_d    = 1'b1;
            if (rrdy_q && !rx_read) roe_d = 1'b1;
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end else if (sclk_fall) begin
          if (bitcnt_q == '0) load = 1'b1;
          else                shift_d = shift_q << 1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      if (primed_q) begin
        shift_d  = tx_hold_q;
        primed_d = 1'b0;
      end else begin
        shift_d = FILL_BYTE;
        toe_d   = 1'b1;
      end
    end

    // Acceptance looks at the pre-load primed flag, so a write racing a fill load is kept.
    if (tx_wr) begin
      if (!primed_q) begin
        tx_hold_d = bus.data_from_cpu[DATA_WIDTH-1:0];
        primed_d  = 1'b1;
      end else begin
        toe_d = 1'b1;
      end
    end

    if (rd) begin
      case (bus.mem_addr)
        3'd0:    rdata_d = 16'(rx_hold_q);
        3'd2:    rdata_d = status;
        3'd3:    rdata_d = {6'b0, ctrl, 2'b00};
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      rx_shift_q <= '0;
      rx_hold_q  <= '0;
      tx_hold_q  <= '0;
      primed_q   <= 1'b0;
      rrdy_q     <= 1'b0;
      fe_q       <= 1'b0;
      roe_q      <= 1'b0;
      toe_q      <= 1'b0;
      eop_q      <= 1'b0;
      armed_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      rx_shift_q <= rx_shift_d;
      rx_hold_q  <= rx_hold_d;
      tx_hold_q  <= tx_hold_d;
      primed_q   <= primed_d;
      rrdy_q     <= rrdy_d;
      fe_q       <= fe_d;
      roe_q      <= roe_d;
      toe_q      <= toe_d;
      eop_q      <= eop_d;
      armed_q    <= armed_d;
      rdata_q    <= rdata_d;
    end
  end

`ifdef SPI_SLAVE_IRQ_EN
  logic [7:0] ctrl_q, ctrl_d;
  logic       irq_q, irq_d;

  always_comb begin
    ctrl_d = ctrl_q;
    if (wr && bus.mem_addr == 3'd3) ctrl_d = bus.data_from_cpu[9:2];
    irq_d = |(status[9:2] & ctrl_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      irq_q  <= irq_d;
    end
  end

  assign ctrl    = ctrl_q;
  assign bus.irq = irq_q;
`else
  assign ctrl    = '0;
  assign bus.irq = 1'b0;
`endif

  assign bus.data_to_cpu   = rdata_q;
  assign bus.dataavailable = rrdy_q;
  assign bus.readyfordata  = trdy;
  assign bus.MISO          = shift_q[DATA_WIDTH-1];
  assign bus.MISO_oe       = (state_q == FRAME);
endmodule

// File: tb/tb_spi_slave_rxm.sv
// Bench for spi_slave_rxm: vector table, directed corner sequences and randomized frames
// against a byte-level model of the register/flag rules.
module tb_spi_slave_rxm;
  localparam int HALF = 80;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  spi_slave_rxm_if bus ();
  spi_slave_rxm dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  bit         m_primed, m_rrdy, m_fe, m_roe, m_toe, m_eop;
  logic [7:0] m_tx, m_rx;
  logic [7:0] fr_mosi [4];
  logic [7:0] fr_miso [4];

  typedef struct {
    bit          do_wr;
    logic [7:0]  txb;
    logic [7:0]  mosib;
    logic [7:0]  exp_miso;
    bit          read_after;
    logic [7:0]  exp_rx;
    logic [15:0] exp_status;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    m_primed = 0; m_rrdy = 0; m_fe = 0; m_roe = 0; m_toe = 0; m_eop = 0;
    m_tx = 8'h00; m_rx = 8'h00;
  endtask

  task automatic m_load(output logic [7:0] b);
    if (m_primed) begin
      b = m_tx;
      m_primed = 0;
    end else begin
      b = 8'hFF;
      m_toe = 1;
    end
  endtask

  task automatic m_write_tx(input logic [7:0] b);
    if (m_primed) m_toe = 1;
    else begin
      m_tx = b;
      m_primed = 1;
    end
  endtask

  task automatic m_rx_byte(input logic [7:0] b);
    if (m_rrdy) m_roe = 1;
    m_rx = b;
    m_rrdy = 1;
  endtask

  function automatic logic [15:0] m_status();
    logic [15:0] s;
    s = 16'h0000;
    s[2] = m_fe;
    s[3] = m_roe;
    s[4] = m_toe;
    s[5] = !m_primed;
    s[6] = !m_primed;
    s[7] = m_rrdy;
    s[8] = m_fe | m_roe | m_toe;
    s[9] = m_eop;
    return s;
  endfunction

  task automatic cpu_wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.spi_select = 1; bus.write_n = 0; bus.mem_addr = a; bus.data_from_cpu = d;
    @(negedge clk);
    bus.spi_select = 0; bus.write_n = 1;
  endtask

  task automatic cpu_rd(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    bus.spi_select = 1; bus.read_n = 0; bus.mem_addr = a;
    @(negedge clk);
    bus.spi_select = 0; bus.read_n = 1;
    d = bus.data_to_cpu;
  endtask

  task automatic clear_status();
    cpu_wr(3'd2, 16'h0000);
    m_fe = 0; m_roe = 0; m_toe = 0; m_eop = 0;
  endtask

  task automatic ss_low();
    bus.SS_n = 0;
    #(100);
  endtask

  task automatic ss_high();
    #(HALF);
    bus.SS_n = 1;
    #(100);
  endtask

  task automatic spi_bits(input int n, input logic [7:0] mo, output logic [7:0] mi, output bit oe_any);
    mi = 8'h00;
    oe_any = 0;
    for (int i = 0; i < n; i++) begin
      bus.MOSI = mo[7-i];
      #(HALF);
      mi[7-i] = bus.MISO;
      oe_any = oe_any | bus.MISO_oe;
      bus.SCLK = 1;
      #(HALF);
      bus.SCLK = 0;
    end
  endtask

  task automatic run_frame(input int nb, input int pb);
    logic [7:0] exp, got;
    bit oe;
    ss_low();
    check("miso_oe_on", bus.MISO_oe, 1);
    m_load(exp);
    for (int i = 0; i < nb; i++) begin
      spi_bits(8, fr_mosi[i], got, oe);
      fr_miso[i] = got;
      check("miso_byte", got, exp);
      m_rx_byte(fr_mosi[i]);
      m_load(exp);
    end
    if (pb > 0) begin
      spi_bits(pb, 8'($urandom), got, oe);
      check("miso_partial", got >> (8 - pb), exp >> (8 - pb));
    end
    ss_high();
    check("miso_oe_off", bus.MISO_oe, 0);
    m_eop = 1;
    if (pb > 0) m_fe = 1;
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] d;
    logic [7:0]  got;
    bit          oe;

    vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 1'b1, 8'h3C, 16'h3F0};
    vecs[1] = '{1'b0, 8'h00, 8'h81, 8'hFF, 1'b0, 8'h00, 16'h3F0};
    vecs[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 1'b1, 8'hFF, 16'h3F8};
    vecs[3] = '{1'b1, 8'h5A, 8'h00, 8'h5A, 1'b1, 8'h00, 16'h3F0};

    bus.spi_select = 0; bus.read_n = 1; bus.write_n = 1; bus.mem_addr = 3'd0;
    bus.data_from_cpu = 16'h0000; bus.SCLK = 0; bus.SS_n = 1; bus.MOSI = 0;
    reset = 1;
    m_reset();
    #30 reset = 0;

    check("rst_data_to_cpu", bus.data_to_cpu, 0);
    check("rst_irq", bus.irq, 0);
    check("rst_miso", bus.MISO, 0);
    check("rst_miso_oe", bus.MISO_oe, 0);
    check("rst_dataavailable", bus.dataavailable, 0);
    check("rst_readyfordata", bus.readyfordata, 1);
    cpu_rd(3'd2, d);
    check("rst_status", d, 16'h060);

    cpu_wr(3'd3, 16'h03FC);
    cpu_rd(3'd3, d);
`ifdef SPI_SLAVE_IRQ_EN
    check("control_rw", d, 16'h03FC);
    cpu_wr(3'd3, 16'h0000);
`else
    check("control_reads_0", d, 16'h0000);
    check("irq_tied_0", bus.irq, 0);
`endif
    cpu_rd(3'd1, d);
    check("txdata_reads_0", d, 0);
    cpu_rd(3'd5, d);
    check("addr5_reads_0", d, 0);

    for (int v = 0; v < 4; v++) begin
      cpu_wr(3'd2, 16'h0000);
      if (vecs[v].do_wr) cpu_wr(3'd1, {8'h00, vecs[v].txb});
      ss_low();
      spi_bits(8, vecs[v].mosib, got, oe);
      ss_high();
      check("vec_miso", got, vecs[v].exp_miso);
      cpu_rd(3'd2, d);
      check("vec_status", d, vecs[v].exp_status);
      if (vecs[v].read_after) begin
        cpu_rd(3'd0, d);
        check("vec_rx", d, {8'h00, vecs[v].exp_rx});
      end
    end
    cpu_wr(3'd2, 16'h0000);
    m_reset();

    // Two bytes in one frame, tx never written, no rx read in between.
    fr_mosi[0] = 8'h11; fr_mosi[1] = 8'h22;
    run_frame(2, 0);
    check("b2b_miso0", fr_miso[0], 8'hFF);
    check("b2b_miso1", fr_miso[1], 8'hFF);
    cpu_rd(3'd2, d);
    check("b2b_status", d, 16'h3F8);
    cpu_rd(3'd0, d); m_rrdy = 0;
    check("b2b_rx", d, 16'h0022);

    // Second txdata write while primed is dropped.
    clear_status();
    cpu_wr(3'd1, 16'h0001); m_write_tx(8'h01);
    cpu_wr(3'd1, 16'h0002); m_write_tx(8'h02);
    cpu_rd(3'd2, d);
    check("dblwr_status", d, 16'h110);
    fr_mosi[0] = 8'h4B;
    run_frame(1, 0);
    check("dblwr_miso", fr_miso[0], 8'h01);

    // Frame aborted after 5 bits with RRDY still set from the previous byte.
    clear_status();
    run_frame(0, 5);
    cpu_rd(3'd2, d);
    check("partial_status", d, 16'h3F4);
    check("partial_rrdy", bus.dataavailable, 1);
    cpu_rd(3'd0, d); m_rrdy = 0;
    check("partial_rx_kept", d, 16'h004B);
    fr_mosi[0] = 8'h96;
    run_frame(1, 0);
    cpu_rd(3'd0, d); m_rrdy = 0;
    check("after_partial_rx", d, 16'h0096);

    // Reset asserted mid-frame and released with SS_n still low.
    ss_low();
    spi_bits(3, 8'hF0, got, oe);
    reset = 1;
    #30 reset = 0;
    m_reset();
    spi_bits(5, 8'h0F, got, oe);
    check("rstmid_oe", oe, 0);
    check("rstmid_rrdy", bus.dataavailable, 0);
    ss_high();
    cpu_rd(3'd2, d);
    check("rstmid_status", d, m_status());
    cpu_wr(3'd1, 16'h00C3); m_write_tx(8'hC3);
    fr_mosi[0] = 8'h5E;
    run_frame(1, 0);
    cpu_rd(3'd0, d); m_rrdy = 0;
    check("rstmid_next_rx", d, 16'h005E);

`ifdef SPI_SLAVE_IRQ_EN
    clear_status();
    cpu_wr(3'd3, 16'h0080);
    cpu_rd(3'd3, d);
    check("irq_ctrl", d, 16'h0080);
    check("irq_idle", bus.irq, 0);
    begin
      logic [7:0] exp;
      ss_low();
      m_load(exp);
      fork
        spi_bits(8, 8'h6D, got, oe);
        begin
          int n;
          n = 0;
          while (!bus.dataavailable && n < 400) begin
            @(negedge clk);
            n++;
          end
          check("irq_rrdy_seen", bus.dataavailable, 1);
          check("irq_lag0", bus.irq, 0);
          @(negedge clk);
          check("irq_lag1", bus.irq, 1);
        end
      join
      check("irq_miso", got, exp);
      m_rx_byte(8'h6D);
      m_load(exp);
      ss_high();
      m_eop = 1;
    end
    cpu_rd(3'd0, d); m_rrdy = 0;
    check("irq_rx", d, 16'h006D);
    check("irq_still_1", bus.irq, 1);
    @(negedge clk);
    check("irq_cleared", bus.irq, 0);
    cpu_wr(3'd3, 16'h0000);
`endif

    for (int it = 0; it < 25; it++) begin
      int nw, nb, pb;
      logic [7:0] b;
      nw = $urandom_range(0, 2);
      for (int k = 0; k < nw; k++) begin
        b = 8'($urandom);
        cpu_wr(3'd1, {8'($urandom), b});
        m_write_tx(b);
      end
      nb = $urandom_range(1, 3);
      for (int i = 0; i < nb; i++) fr_mosi[i] = 8'($urandom);
      pb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      run_frame(nb, pb);
      cpu_rd(3'd2, d);
      check("rand_status", d, m_status());
      if ($urandom_range(0, 1) == 1) begin
        cpu_rd(3'd0, d);
        check("rand_rx", d, {8'h00, m_rx});
        m_rrdy = 0;
      end
      if ($urandom_range(0, 1) == 1) clear_status();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
